// File: rtl/frontend_command_definition_pkg.sv
// Shared definitions for the frontend command path: dispatch buffer occupancy
// states and the dispatch counter width.
package frontend_command_definition_pkg;

    typedef enum logic [1:0] {
        OCC0 = 2'd0,
        OCC1 = 2'd1,
        OCC2 = 2'd2
    } occ_e;

    localparam int DISP_CNT_W = 16;

endpackage

// File: rtl/fifo_rd_dispatch.sv
// Pops words from a FIFO read port into a 2-entry in-order buffer and presents them
// downstream with valid/ready. Define FIFO_RD_DISPATCH_CNT_EN to add the o_disp_cnt counter.
module fifo_rd_dispatch
    import frontend_command_definition_pkg::*;
#(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_fifo_data,
    input  logic                  i_fifo_empty,
    output logic                  o_fifo_rd_en,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    input  logic                  i_ready,
    output logic [1:0]            o_occ
`ifdef FIFO_RD_DISPATCH_CNT_EN
    ,
    output logic [DISP_CNT_W-1:0] o_disp_cnt
`endif
);

    occ_e                  state, nxt;
    logic [DATA_WIDTH-1:0] tail;
    logic                  pop, accept;

    // Pop decision uses registered state only; i_ready never reaches rd_en.
    assign o_fifo_rd_en = !i_rst && !i_fifo_empty && (state != OCC2) && !i_flush;
    assign pop          = o_fifo_rd_en;
    assign accept       = o_valid && i_ready;

    always_comb begin
        nxt = state;
        if (i_flush) begin
            nxt = OCC0;
        end else begin
            case (state)
                OCC0:    if (pop) nxt = OCC1;
                OCC1:    if (pop && !accept) nxt = OCC2;
                         else if (!pop && accept) nxt = OCC0;
                OCC2:    if (accept) nxt = OCC1;
                default: nxt = OCC0;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= OCC0;
            o_valid <= 1'b0;
            o_occ   <= 2'd0;
            o_data  <= '0;
            tail    <= '0;
        end else begin
            state   <= nxt;
            o_valid <= (nxt != OCC0);
            o_occ   <= nxt;
            if (!i_flush) begin
                case (state)
                    OCC0:    if (pop) o_data <= i_fifo_data;
                    OCC1:    if (pop && accept) o_data <= i_fifo_data;
                             else if (pop) tail <= i_fifo_data;
                    OCC2:    if (accept) o_data <= tail;
                    default: ;
                endcase
            end
        end
    end

`ifdef FIFO_RD_DISPATCH_CNT_EN
    // A flush discards the presented command, so it is not counted as dispatched.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            o_disp_cnt <= '0;
        else if (accept && !i_flush)
            o_disp_cnt <= o_disp_cnt + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_dispatch.sv
// Directed bench for fifo_rd_dispatch: a FIFO model feeds the DUT, popped words are
// queued as expected commands and compared against what the DUT presents.
module tb_fifo_rd_dispatch;
    import frontend_command_definition_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_fifo_data;
    logic       i_fifo_empty;
    logic       o_fifo_rd_en;
    logic       i_flush = 1'b0;
    logic       o_valid;
    logic [3:0] o_data;
    logic       i_ready = 1'b0;
    logic [1:0] o_occ;
`ifdef FIFO_RD_DISPATCH_CNT_EN
    logic [15:0] o_disp_cnt;
`endif

    fifo_rd_dispatch #(.DATA_WIDTH(4)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_fifo_data  (i_fifo_data),
        .i_fifo_empty (i_fifo_empty),
        .o_fifo_rd_en (o_fifo_rd_en),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .o_data       (o_data),
        .i_ready      (i_ready),
        .o_occ        (o_occ)
`ifdef FIFO_RD_DISPATCH_CNT_EN
        ,
        .o_disp_cnt   (o_disp_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // FIFO model: circular store, read pointer advanced by the DUT's pop.
    logic [3:0] mem [0:63];
    logic [5:0] rd_ptr = '0;
    logic [5:0] wr_ptr = '0;
    assign i_fifo_data  = mem[rd_ptr];
    assign i_fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge i_clk) if (o_fifo_rd_en) rd_ptr <= rd_ptr + 6'd1;

    logic [3:0]  exp_q [$];
    logic        zero_data;
    logic [15:0] exp_cnt = '0;
    int checks = 0;
    int failures = 0;

    task automatic push(input logic [3:0] v);
        mem[wr_ptr] = v;
        wr_ptr = wr_ptr + 6'd1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        chk("occ", {30'd0, o_occ}, exp_q.size());
        chk("valid", {31'd0, o_valid}, {31'd0, exp_q.size() != 0});
        if (exp_q.size() != 0) chk("data", {28'd0, o_data}, {28'd0, exp_q[0]});
        else if (zero_data)    chk("data_rst", {28'd0, o_data}, 32'd0);
`ifdef FIFO_RD_DISPATCH_CNT_EN
        chk("disp_cnt", {16'd0, o_disp_cnt}, {16'd0, exp_cnt});
`endif
    endtask

    // One clock cycle: drive inputs, check the pop request, update the scoreboard,
    // then sample outputs on the falling edge.
    task automatic step(input logic rdy, input logic fl, input logic rst);
        logic exp_rd;
        i_ready = rdy;
        i_flush = fl;
        i_rst   = rst;
        #1;
        exp_rd = !rst && !fl && (rd_ptr != wr_ptr) && (exp_q.size() < 2);
        chk("rd_en", {31'd0, o_fifo_rd_en}, {31'd0, exp_rd});
        if (rst) begin
            exp_q.delete();
            zero_data = 1'b1;
            exp_cnt   = '0;
        end else if (fl) begin
            exp_q.delete();
        end else begin
            if (rdy && exp_q.size() != 0) begin
                void'(exp_q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (exp_rd) begin
                exp_q.push_back(mem[rd_ptr]);
                zero_data = 1'b0;
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
        check_outputs();
    endtask

    initial begin
        zero_data = 1'b1;
        // Reset with a non-empty FIFO: nothing may be popped.
        push(4'h9);
        step(0, 0, 1);
        step(0, 0, 1);
        repeat (3) step(1, 0, 0);

        // Streaming at one command per cycle.
        for (int i = 1; i <= 8; i++) push(i[3:0]);
        repeat (10) step(1, 0, 0);

        // Backpressure: fill to two entries, hold, then drain in order.
        push(4'h3); push(4'h5); push(4'h7);
        repeat (3) step(0, 0, 0);
        repeat (4) step(1, 0, 0);

        // Flush with a full buffer and a concurrent accept; FIFO kept non-empty.
        push(4'hA); push(4'hB);
        repeat (2) step(0, 0, 0);
        push(4'hC);
        step(1, 1, 0);
        repeat (3) step(1, 0, 0);

        // Empty FIFO, then a single word.
        repeat (3) step(1, 0, 0);
        push(4'hC);
        repeat (3) step(1, 0, 0);

        // Reset mid-stream drops buffered commands without popping.
        push(4'h1); push(4'h2); push(4'h3);
        repeat (2) step(0, 0, 0);
        step(1, 0, 1);
        repeat (3) step(1, 0, 0);

`ifdef FIFO_RD_DISPATCH_CNT_EN
        // Drive the counter to 0xFFFE, then observe the wrap.
        for (int n = 0; n < 70000 && exp_cnt != 16'hFFFE; n++) begin
            push(n[3:0]);
            step(1, 0, 0);
        end
        chk("cnt_preload", {16'd0, o_disp_cnt}, 32'h0000_FFFE);
        for (int n = 0; n < 3; n++) begin
            push(4'h6);
            step(1, 0, 0);
        end
        repeat (2) step(1, 0, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
